// File: rtl/filter_pkg.sv
// filter_pkg
// Shared definitions for the 3x3 window generator: default image geometry,
// default pixel width and the frame-control FSM state encoding.
// No ports; imported by window_gen and line_buffer.
package filter_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 8;
    localparam int IMG_H_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// line_buffer
// Fixed-depth shift register used to delay the raster stream by exactly one
// image line. Data is stored and forwarded untouched.
// Ports:
//   clk     - clock, storage updates on the rising edge
//   shift_i - advance the line by one pixel
//   din_i   - pixel entering the line
//   dout_o  - pixel that entered DEPTH shifts ago (valid before the shift)
module line_buffer
    import filter_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Line storage: shifts one place per accepted pixel, holds otherwise.
    // Contents are don't-care after reset because no window is emitted
    // until a full two lines have passed through.
    always_ff @(posedge clk) begin
        if (shift_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// window_gen
// Converts a raster pixel stream into a stream of 3x3 neighbourhood windows
// for every interior pixel of an IMG_W x IMG_H frame.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   en                - start pulse, arms a new frame (only honoured in IDLE)
//   in_valid/in_ready - raster pixel handshake, pixel on in_pixel
//   out_valid/out_ready - window handshake, window on w1..w9 (row-major,
//                       w1 top-left, w5 centre, w9 bottom-right)
//   done              - one-cycle pulse after the last window is consumed
module window_gen
    import filter_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] w1,
    output logic [PIX_W-1:0] w2,
    output logic [PIX_W-1:0] w3,
    output logic [PIX_W-1:0] w4,
    output logic [PIX_W-1:0] w5,
    output logic [PIX_W-1:0] w6,
    output logic [PIX_W-1:0] w7,
    output logic [PIX_W-1:0] w8,
    output logic [PIX_W-1:0] w9,
    output logic             done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];

    logic             in_ready_s;
    logic             accept_s;
    logic             xfer_s;
    logic             last_pix_s;
    logic             corner_s;
    logic             win_ok_s;
    logic [PIX_W-1:0] lb0_dout_s;
    logic [PIX_W-1:0] lb1_dout_s;

    assign accept_s   = in_valid & in_ready_s;
    assign xfer_s     = out_valid_q & out_ready;
    assign last_pix_s = accept_s & (row_q == ROW_LAST) & (col_q == COL_LAST);
    assign corner_s   = accept_s & (row_q == ROW_TWO) & (col_q == COL_TWO);
    // Pixel (r,c) completes the window centred on (r-1,c-1); that centre is
    // interior only when r>=2 and c>=2, which also rules out row wraps.
    assign win_ok_s   = (row_q >= ROW_TWO) & (col_q >= COL_TWO);

    // lb0 yields the pixel one line above the incoming one, lb1 two lines above.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .shift_i (accept_s),
        .din_i   (in_pixel),
        .dout_o  (lb0_dout_s)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .shift_i (accept_s),
        .din_i   (lb0_dout_s),
        .dout_o  (lb1_dout_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the last-pixel test wins so a 3x3 frame goes
    // straight from FILL to FLUSH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (last_pix_s) begin
                    state_d = FLUSH;
                end else if (corner_s) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                if (last_pix_s) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (xfer_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only accept a pixel when the window register can move.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            FILL, RUN: in_ready_s = ~out_valid_q | out_ready;
            IDLE, FLUSH: in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if ((state_q == IDLE) && en) begin
            col_d = '0;
            row_d = '0;
        end else if (accept_s) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Window shift and output handshake. The window only moves on accepted
    // pixels, which can only happen when no valid window is being held.
    always_comb begin
        win_d       = win_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        if (accept_s) begin
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2]    = lb1_dout_s;
            win_d[3]    = win_q[4];
            win_d[4]    = win_q[5];
            win_d[5]    = lb0_dout_s;
            win_d[6]    = win_q[7];
            win_d[7]    = win_q[8];
            win_d[8]    = in_pixel;
            out_valid_d = win_ok_s;
        end else if (xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if ((state_q == FLUSH) && xfer_s) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            win_q       <= win_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign w1 = win_q[0];
    assign w2 = win_q[1];
    assign w3 = win_q[2];
    assign w4 = win_q[3];
    assign w5 = win_q[4];
    assign w6 = win_q[5];
    assign w7 = win_q[6];
    assign w8 = win_q[7];
    assign w9 = win_q[8];

endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic       done;
    logic [71:0] win_s;

    int total = 0;
    int bad   = 0;

    logic [7:0]  frame_mem [NPIX];
    logic [71:0] sb_q [$];
    int          acc_idx    = 0;
    int          win_cnt    = 0;
    int          done_cnt   = 0;
    int          bad_center = 0;
    logic        tb_idle    = 1'b1;
    logic        ramp_frame = 1'b1;
    logic [71:0] first_win  = '0;
    logic [71:0] last_win   = '0;
    logic        exp_ov_pend = 1'b0;
    logic        exp_ov_val  = 1'b0;
    logic        stall_prev  = 1'b0;
    logic [71:0] held_win    = '0;
    logic        done_prev   = 1'b0;

    window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .w1 (w1), .w2 (w2), .w3 (w3),
        .w4 (w4), .w5 (w5), .w6 (w6),
        .w7 (w7), .w8 (w8), .w9 (w9),
        .done      (done)
    );

    assign win_s = {w1, w2, w3, w4, w5, w6, w7, w8, w9};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected window for centre (r,c), w1 in the top byte.
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                v = {v[63:0], frame_mem[(r + dr) * W + (c + dc)]};
            end
        end
        return v;
    endfunction

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        int r;
        int c;
        if (rst) begin
            sb_q.delete();
            exp_ov_pend = 1'b0;
            stall_prev  = 1'b0;
            done_prev   = 1'b0;
        end else begin
            if (exp_ov_pend) begin
                check_eq("latency_out_valid", 72'(out_valid), 72'(exp_ov_val));
            end
            exp_ov_pend = 1'b0;
            if (stall_prev) begin
                check_eq("stall_hold_window", win_s, held_win);
                check_eq("stall_hold_valid", 72'(out_valid), 72'(1));
            end
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", 72'(in_ready), 72'(0));
                stall_prev = 1'b1;
                held_win   = win_s;
            end else begin
                stall_prev = 1'b0;
            end
            if (done) begin
                check_eq("done_single_cycle", 72'(done_prev), 72'(0));
                check_eq("done_after_all_windows", 72'(sb_q.size()), 72'(0));
                check_eq("done_window_count", 72'(win_cnt), 72'(NWIN));
                done_cnt++;
            end
            done_prev = done;
            if (en && tb_idle) begin
                acc_idx = 0;
                win_cnt = 0;
            end
            if (out_valid && out_ready) begin
                check_eq("window_expected", 72'(sb_q.size() > 0), 72'(1));
                if (sb_q.size() > 0) begin
                    check_eq("window_value", win_s, sb_q.pop_front());
                end
                if (win_cnt == 0) first_win = win_s;
                last_win = win_s;
                win_cnt++;
                if (ramp_frame && (w5 == 8'd15 || w5 == 8'd16)) bad_center++;
            end
            if (in_valid && in_ready) begin
                r = acc_idx / W;
                c = acc_idx % W;
                if (r >= 2 && c >= 2) sb_q.push_back(exp_win(r - 1, c - 1));
                exp_ov_pend = 1'b1;
                exp_ov_val  = (r >= 2 && c >= 2);
                acc_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 plain, 1 mid-row stall, 2 idle in_valid + en during RUN,
    // 3 random data with bubbles/backpressure; abort_at>0 resets mid-frame.
    task automatic run_frame(input int mode, input int abort_at);
        int   drv_idx;
        int   cyc;
        int   done_before;
        int   stall_left;
        logic stall_done;
        logic acc;
        drv_idx     = 0;
        cyc         = 0;
        stall_left  = 0;
        stall_done  = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            frame_mem[i] = (mode == 3) ? 8'($urandom) : 8'(i);
        end
        ramp_frame  = (mode != 3);
        bad_center  = 0;
        done_before = done_cnt;
        out_ready   = 1'b1;
        if (mode == 2) begin
            in_valid = 1'b1;
            in_pixel = 8'hAA;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_eq("idle_in_ready", 72'(in_ready), 72'(0));
                tick();
            end
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        tb_idle = 1'b0;
        while (drv_idx < NPIX && cyc < 3000) begin
            in_valid  = (mode == 3) ? ($urandom_range(3, 0) != 0) : 1'b1;
            in_pixel  = frame_mem[drv_idx];
            out_ready = 1'b1;
            if (mode == 1 && drv_idx == 20 && !stall_done) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (mode == 3) out_ready = ($urandom_range(9, 0) < 7);
            en = (mode == 2 && drv_idx == 40);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) drv_idx++;
            if (abort_at > 0 && drv_idx == abort_at) break;
        end
        in_valid = 1'b0;
        en       = 1'b0;
        if (abort_at > 0) begin
            rst = 1'b1;
            @(negedge clk);
            check_eq("abort_out_valid", 72'(out_valid), 72'(0));
            check_eq("abort_in_ready", 72'(in_ready), 72'(0));
            check_eq("abort_done", 72'(done), 72'(0));
            check_eq("abort_window", win_s, 72'(0));
            tick();
            rst     = 1'b0;
            tb_idle = 1'b1;
            in_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check_eq("post_abort_quiet", 72'({out_valid, done, in_ready}), 72'(0));
                tick();
            end
            in_valid = 1'b0;
            check_eq("abort_no_done", 72'(done_cnt - done_before), 72'(0));
            return;
        end
        check_eq("drive_complete", 72'(drv_idx), 72'(NPIX));
        cyc = 0;
        while (done_cnt == done_before && cyc < 200) begin
            out_ready = (mode == 3) ? ($urandom_range(9, 0) < 7) : 1'b1;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("frame_done_pulses", 72'(done_cnt - done_before), 72'(1));
        check_eq("frame_window_count", 72'(win_cnt), 72'(NWIN));
        @(negedge clk);
        check_eq("frame_end_in_ready", 72'(in_ready), 72'(0));
        if (ramp_frame) begin
            check_eq("first_window", first_win, 72'h00_01_02_08_09_0A_10_11_12);
            check_eq("last_w5", 72'(last_win[39:32]), 72'(54));
            check_eq("last_w9", 72'(last_win[7:0]), 72'(63));
            check_eq("no_wrap_center", 72'(bad_center), 72'(0));
        end
        tick();
        tb_idle = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 72'({out_valid, in_ready, done}), 72'(0));
        check_eq("reset_window", win_s, 72'(0));
        tick();
        rst = 1'b0;
        tick();
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(0, 30);
        run_frame(0, 0);
        run_frame(3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
